// File: rtl/srt2_div_ctrl_if.sv
// Handshake and datapath-control bundle between the SRT radix-2 divider
// datapath (master side: status into the sequencer) and the sequencer.
interface srt2_div_ctrl_if;
  // Requests and datapath status toward the sequencer
  logic       start;
  logic       b_msb;
  logic       b_zero;
  logic [2:0] p_top;
  logic       p_sign;
  // Register controls back to the datapath
  logic       ld_all;
  logic       b_lshift;
  logic       pq_lshift;
  logic       q_shin;
  logic       qp_lshift;
  logic       qp_shin;
  logic       qp_cup;
  logic       add_en;
  logic       add_op;
  logic       q_conv;
  logic       p_rshift;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] k_out;

  modport master (
    output start, b_msb, b_zero, p_top, p_sign,
    input  ld_all, b_lshift, pq_lshift, q_shin, qp_lshift, qp_shin, qp_cup,
           add_en, add_op, q_conv, p_rshift, busy, done, err, k_out
  );

  modport slave (
    input  start, b_msb, b_zero, p_top, p_sign,
    output ld_all, b_lshift, pq_lshift, q_shin, qp_lshift, qp_shin, qp_cup,
           add_en, add_op, q_conv, p_rshift, busy, done, err, k_out
  );
endinterface

// File: rtl/srt2_div_ctrl.sv
// Control sequencer for the 8-bit SRT radix-2 divider: normalizes the divisor,
// selects 8 quotient digits from the top partial-remainder bits, applies the
// final sign correction, converts Q - Q' and denormalizes the remainder.
module srt2_div_ctrl (
  input  logic           clk,
  input  logic           rst_b,
  srt2_div_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_NORM   = 3'd2,
    S_ITER   = 3'd3,
    S_CORR   = 3'd4,
    S_CONV   = 3'd5,
    S_DENORM = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] k_q, k_d;
  logic       err_q, err_d;

  logic ld_all, b_lshift, pq_lshift, q_shin, qp_lshift, qp_shin, qp_cup;
  logic add_en, add_op, q_conv, p_rshift;

  // State, digit counter, normalization count and error flag registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      k_q     <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and combinational datapath controls
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    err_d     = err_q;
    ld_all    = 1'b0;
    b_lshift  = 1'b0;
    pq_lshift = 1'b0;
    q_shin    = 1'b0;
    qp_lshift = 1'b0;
    qp_shin   = 1'b0;
    qp_cup    = 1'b0;
    add_en    = 1'b0;
    add_op    = 1'b0;
    q_conv    = 1'b0;
    p_rshift  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        ld_all  = 1'b1;
        cnt_d   = 3'd0;
        k_d     = 3'd0;
        state_d = S_NORM;
      end
      S_NORM: begin
        // A zero divisor never normalizes, so it must be caught before shifting
        if (bus.b_zero) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!bus.b_msb) begin
          b_lshift  = 1'b1;
          pq_lshift = 1'b1;
          q_shin    = 1'b0;
          k_d       = k_q + 3'd1;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        pq_lshift = 1'b1;
        qp_lshift = 1'b1;
        // Digit selection on the three bits that land in P[8:6] after the shift
        case (bus.p_top)
          3'b001, 3'b010, 3'b011: begin
            q_shin = 1'b1;
            add_en = 1'b1;
            add_op = 1'b1;
          end
          3'b100, 3'b101, 3'b110: begin
            qp_shin = 1'b1;
            add_en  = 1'b1;
            add_op  = 1'b0;
          end
          default: begin
            q_shin  = 1'b0;
            qp_shin = 1'b0;
          end
        endcase
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_CORR;
        end else begin
          state_d = S_ITER;
        end
      end
      S_CORR: begin
        // Negative remainder: add B back and bump Q' so Q - Q' drops by one
        if (bus.p_sign) begin
          add_en = 1'b1;
          add_op = 1'b0;
          qp_cup = 1'b1;
        end else begin
          add_en = 1'b0;
        end
        state_d = S_CONV;
      end
      S_CONV: begin
        q_conv  = 1'b1;
        state_d = S_DENORM;
      end
      S_DENORM: begin
        if (k_q != 3'd0) begin
          p_rshift = 1'b1;
          k_d      = k_q - 3'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ld_all    = ld_all;
  assign bus.b_lshift  = b_lshift;
  assign bus.pq_lshift = pq_lshift;
  assign bus.q_shin    = q_shin;
  assign bus.qp_lshift = qp_lshift;
  assign bus.qp_shin   = qp_shin;
  assign bus.qp_cup    = qp_cup;
  assign bus.add_en    = add_en;
  assign bus.add_op    = add_op;
  assign bus.q_conv    = q_conv;
  assign bus.p_rshift  = p_rshift;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
  assign bus.k_out     = k_q;

endmodule

// File: tb/tb_srt2_div_ctrl.sv
// Directed, table-driven bench for the SRT radix-2 divider sequencer.
module tb_srt2_div_ctrl;

  logic clk;
  logic rst_b;
  srt2_div_ctrl_if bus_if ();

  srt2_div_ctrl dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-output bit positions in a packed 17-bit vector
  localparam logic [16:0] LD  = 17'h10000;
  localparam logic [16:0] BL  = 17'h08000;
  localparam logic [16:0] PQ  = 17'h04000;
  localparam logic [16:0] QS  = 17'h02000;
  localparam logic [16:0] QPL = 17'h01000;
  localparam logic [16:0] QPS = 17'h00800;
  localparam logic [16:0] CUP = 17'h00400;
  localparam logic [16:0] AE  = 17'h00200;
  localparam logic [16:0] AOP = 17'h00100;
  localparam logic [16:0] CV  = 17'h00080;
  localparam logic [16:0] PR  = 17'h00040;
  localparam logic [16:0] BZ  = 17'h00020;
  localparam logic [16:0] DN  = 17'h00010;
  localparam logic [16:0] ER  = 17'h00008;
  localparam logic [16:0] NONE = 17'h00000;

  typedef struct {
    logic        start;
    logic        b_msb;
    logic        b_zero;
    logic [2:0]  p_top;
    logic        p_sign;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   bad;

  function automatic logic [16:0] kk(input int k);
    logic [2:0] k3;
    k3 = k[2:0];
    return {14'd0, k3};
  endfunction

  task automatic add(input logic st, input logic bm, input logic bz,
                     input logic [2:0] pt, input logic ps, input logic [16:0] ex);
    vec_t v;
    v.start = st; v.b_msb = bm; v.b_zero = bz; v.p_top = pt; v.p_sign = ps; v.exp = ex;
    vecs.push_back(v);
  endtask

  function automatic logic [16:0] actual();
    return {bus_if.ld_all, bus_if.b_lshift, bus_if.pq_lshift, bus_if.q_shin,
            bus_if.qp_lshift, bus_if.qp_shin, bus_if.qp_cup, bus_if.add_en,
            bus_if.add_op, bus_if.q_conv, bus_if.p_rshift, bus_if.busy,
            bus_if.done, bus_if.err, bus_if.k_out};
  endfunction

  task automatic check(input string nm, input int idx, input logic [16:0] ex);
    logic [16:0] a;
    a = actual();
    total++;
    if (a !== ex) begin
      bad++;
      $display("FAIL %s[%0d]: got %b expected %b", nm, idx, a, ex);
    end
  endtask

  // Drive a vector's inputs at the falling edge and check outputs just after
  task automatic apply(input vec_t v, input string nm, input int idx);
    @(negedge clk);
    bus_if.start  = v.start;
    bus_if.b_msb  = v.b_msb;
    bus_if.b_zero = v.b_zero;
    bus_if.p_top  = v.p_top;
    bus_if.p_sign = v.p_sign;
    #1;
    check(nm, idx, v.exp);
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], nm, i);
    vecs.delete();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_b = 1'b0;
    bus_if.start = 1'b0; bus_if.b_msb = 1'b0; bus_if.b_zero = 1'b0;
    bus_if.p_top = 3'd0; bus_if.p_sign = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_hold", 0, NONE);
    @(negedge clk);
    rst_b = 1'b1;

    // ---- k=0 run: digit mapping, start ignored in ITER, correction, back-to-back
    add(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, NONE);               // IDLE, start sampled (E0)
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, LD | BZ);            // LOAD
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, BZ);                 // NORM, already normalized
    add(1'b0, 1'b1, 1'b0, 3'b011, 1'b0, PQ|QPL|BZ|AE|AOP|QS); // digit +1
    add(1'b1, 1'b1, 1'b0, 3'b100, 1'b0, PQ|QPL|BZ|AE|QPS);   // digit -1, start ignored
    add(1'b0, 1'b1, 1'b0, 3'b111, 1'b0, PQ|QPL|BZ);          // digit 0
    add(1'b1, 1'b1, 1'b0, 3'b001, 1'b0, PQ|QPL|BZ|AE|AOP|QS);
    add(1'b0, 1'b1, 1'b0, 3'b110, 1'b0, PQ|QPL|BZ|AE|QPS);
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, PQ|QPL|BZ);
    add(1'b0, 1'b1, 1'b0, 3'b010, 1'b0, PQ|QPL|BZ|AE|AOP|QS);
    add(1'b0, 1'b1, 1'b0, 3'b101, 1'b0, PQ|QPL|BZ|AE|QPS);   // 8th ITER (E10)
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, BZ|AE|CUP);          // CORR, negative remainder
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, BZ|CV);              // CONV at E12
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, BZ);                 // DENORM, k=0
    add(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, BZ|DN);              // DONE at E14, start ignored
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, NONE);               // IDLE, not started
    // ---- k=3 run
    add(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, NONE);               // E0
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, LD|BZ);              // LOAD
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, BL|PQ|BZ|kk(0));     // NORM shift 1
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, BL|PQ|BZ|kk(1));     // NORM shift 2
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, BL|PQ|BZ|kk(2));     // NORM shift 3
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, BZ|kk(3));           // NORM done
    for (int i = 0; i < 8; i++)
      add(1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 3'b000 : 3'b111, 1'b1, PQ|QPL|BZ|kk(3));
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, BZ|kk(3));           // CORR, positive remainder
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, CV|BZ|kk(3));        // CONV
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, PR|BZ|kk(3));        // DENORM
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, PR|BZ|kk(2));
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, PR|BZ|kk(1));
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, BZ|kk(0));           // DENORM exits
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, DN|BZ);              // DONE at E20
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, NONE);
    run_table("run");

    // ---- divide by zero, err held, cleared by next accepted start
    add(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, NONE);               // E0
    add(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, LD|BZ);              // E1
    add(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, BZ);                 // E2 NORM, no shift
    add(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, DN|ER|BZ);           // E3 DONE with err
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, ER);                 // IDLE, err held
    add(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, ER);                 // start accepted this edge
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, LD|BZ);              // err cleared
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, BL|PQ|BZ);           // NORM shift, k 0->1
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, BZ|kk(1));
    add(1'b0, 1'b1, 1'b0, 3'b011, 1'b0, PQ|QPL|BZ|AE|AOP|QS|kk(1));
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, PQ|QPL|BZ|kk(1));
    run_table("zdiv");

    // ---- async reset mid-ITER
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1 check("rst_async", 0, NONE);
    @(negedge clk);
    rst_b = 1'b1;
    #1 check("rst_release", 0, NONE);
    add(1'b0, 1'b1, 1'b0, 3'b011, 1'b1, NONE);               // stays IDLE, controls idle
    add(1'b0, 1'b1, 1'b0, 3'b011, 1'b1, NONE);
    add(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, NONE);
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, LD|BZ);
    run_table("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
